msdap_out_serializer: RTL

Output stage directly downstream of the MSDAP ALU. It captures each 40-bit filter result `y` when the ALU flags it ready. It then shifts the result out MSB-first, one bit per `Sclk`, aligned to the next `Frame` pulse, and asserts `OutReady` for exactly the 40 bit-cycles. A one-deep holding register decouples ALU completion from frame timing, so a new result can arrive while the previous one is still shifting.

---
 rtl/msdap_pkg.sv | 12 +
 rtl/msdap_out_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/msdap_pkg.sv
// Shared MSDAP definitions: result width, counter width and output-stage state encoding.
package msdap_pkg;

  localparam int OUT_WIDTH = 40;
  localparam int OUT_CNT_W = 6;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } out_state_t;

endpackage

// File: rtl/msdap_out_serializer.sv
// MSDAP output stage: holds one ALU result and shifts it out MSB-first on the next Frame,
// flagging OutReady for exactly WIDTH bit-cycles.
module msdap_out_serializer
  import msdap_pkg::*;
#(
  parameter int WIDTH = OUT_WIDTH,
  parameter int CNT_W = OUT_CNT_W
) (
  input  logic             Sclk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] y,
  input  logic             y_valid,
  input  logic             Frame,
  input  logic             sleep,
  output logic             OutputData,
  output logic             OutReady,
  output logic             busy,
  output logic             overflow
);

  out_state_t       state_r;
  out_state_t       state_next_s;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full_r;
  logic [WIDTH-1:0] sr_r;
  logic [CNT_W-1:0] bit_cnt_r;

  logic [WIDTH-1:0] hold_next_s;
  logic             hold_full_next_s;
  logic [WIDTH-1:0] sr_next_s;
  logic [CNT_W-1:0] bit_cnt_next_s;
  logic             out_data_next_s;
  logic             out_ready_next_s;
  logic             overflow_next_s;

  logic launch_s;
  logic capture_s;
  logic drop_s;
  logic shift_done_s;

  // A launch empties the holding register in the same edge, so a coincident result is kept.
  assign launch_s     = (state_r == ST_IDLE) && Frame && hold_full_r && !sleep;
  assign capture_s    = y_valid && (!hold_full_r || launch_s);
  assign drop_s       = y_valid && hold_full_r && !launch_s;
  assign shift_done_s = (state_r == ST_SHIFT) && (bit_cnt_r == {CNT_W{1'b0}});
  assign busy         = (state_r == ST_SHIFT) || hold_full_r;

  // State register
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; the exit edge follows the last-bit edge so OutReady spans WIDTH cycles
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) state_next_s = ST_SHIFT;
        else          state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (shift_done_s) state_next_s = ST_IDLE;
        else              state_next_s = ST_SHIFT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values for the shifter, counter, holding register and registered outputs
  always_comb begin
    sr_next_s        = sr_r;
    bit_cnt_next_s   = bit_cnt_r;
    out_data_next_s  = 1'b0;
    out_ready_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          sr_next_s        = hold_r << 1;
          bit_cnt_next_s   = CNT_W'(WIDTH - 1);
          out_data_next_s  = hold_r[WIDTH-1];
          out_ready_next_s = 1'b1;
        end else begin
          out_data_next_s  = 1'b0;
          out_ready_next_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (shift_done_s) begin
          out_data_next_s  = 1'b0;
          out_ready_next_s = 1'b0;
        end else begin
          sr_next_s        = sr_r << 1;
          bit_cnt_next_s   = bit_cnt_r - CNT_W'(1'b1);
          out_data_next_s  = sr_r[WIDTH-1];
          out_ready_next_s = 1'b1;
        end
      end
      default: begin
        sr_next_s        = {WIDTH{1'b0}};
        bit_cnt_next_s   = {CNT_W{1'b0}};
        out_data_next_s  = 1'b0;
        out_ready_next_s = 1'b0;
      end
    endcase

    hold_next_s      = hold_r;
    hold_full_next_s = hold_full_r;
    if (capture_s) begin
      hold_next_s      = y;
      hold_full_next_s = 1'b1;
    end else if (launch_s) begin
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end

    if (drop_s) overflow_next_s = 1'b1;
    else        overflow_next_s = overflow;
  end

  // Datapath and output registers
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      sr_r        <= {WIDTH{1'b0}};
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
      bit_cnt_r   <= {CNT_W{1'b0}};
      OutputData  <= 1'b0;
      OutReady    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sr_r        <= sr_next_s;
      hold_r      <= hold_next_s;
      hold_full_r <= hold_full_next_s;
      bit_cnt_r   <= bit_cnt_next_s;
      OutputData  <= out_data_next_s;
      OutReady    <= out_ready_next_s;
      overflow    <= overflow_next_s;
    end
  end

endmodule
